ram_b_scan_reader: RTL
======================

Name: ram_b_scan_reader

Overview:
Sequential read-side counterpart to the switch-driven RAM_B write/test path. When started, it walks the 32-bit RAM_B word memory from address 0 to LAST_ADDR and respects the RAM's registered read latency. It shows each word on the 8 LEDs one byte at a time, with a programmable dwell per byte, and accumulates an XOR checksum of every word read. It drives the RAM_B port (read-only) in place of the manual switch interface.

Parameters:
ADDR_W, 6, RAM_B address width (word address, byte offset dropped)
LAST_ADDR, 63, final word address scanned (0..2^ADDR_W-1)
RD_LAT, 1, RAM read latency in clocks (address sampled -> douta valid), >=1
DWELL, 25000000, clocks each byte stays on LED, >=1

Ports:
Clk  in  1  system clock; also drives RAM_B clka
Rst_n  in  1  synchronous active-low reset
Start  in  1  level input; a rising edge (sampled low then high) launches a scan
Hold  in  1  high freezes the dwell counter (pause display)
Mem_Addr  out  ADDR_W  word address to RAM_B addra
Mem_Write  out  1  RAM_B wea; tied 0 (never writes)
M_R_Data  in  32  RAM_B douta
LED  out  8  currently displayed byte
Byte_Sel  out  2  index of displayed byte (0 = bits 7:0 ... 3 = bits 31:24)
Busy  out  1  high from scan launch until DONE is entered
Done  out  1  high in DONE state
Checksum  out  32  running XOR of all words captured in current scan

Behaviour:
- One clock domain (Clk). Reset is synchronous and active-low: Rst_n sampled low at a Clk edge resets the block.
- Reset values: state IDLE, Mem_Addr 0, LED 0, Byte_Sel 0, Busy 0, Done 0, Checksum 0, word register 0, dwell counter 0, latency counter 0, Start history 0. Mem_Write is always 0.
- Reset mid-scan aborts immediately; the next edge with Rst_n high resumes from IDLE.
- Start edge detect: a 1-flop history register; launch = Start & ~Start_d.
- States: IDLE, REQ, WAIT, SHOW, DONE.
- IDLE: on launch -> REQ; Mem_Addr<=0, Checksum<=0, Busy<=1.
- REQ: lasts 1 cycle with Mem_Addr stable (the RAM samples it at the edge ending REQ) -> WAIT; latency counter<=0.
- WAIT: lasts RD_LAT cycles. At the edge ending the last WAIT cycle: word register<=M_R_Data, Checksum<=Checksum^M_R_Data, Byte_Sel<=0, LED<=M_R_Data[7:0], dwell counter<=0 -> SHOW.
- SHOW: the dwell counter increments each cycle when Hold=0 and holds when Hold=1.
  - When the counter is DWELL-1 and Hold=0, the counter goes to 0.
  - If Byte_Sel<3: Byte_Sel++ and LED<=the next byte of the word register.
  - If Byte_Sel==3 and Mem_Addr!=LAST_ADDR: Mem_Addr++ -> REQ. LED and Byte_Sel hold until the next capture.
  - If Byte_Sel==3 and Mem_Addr==LAST_ADDR: Busy<=0, Done<=1 -> DONE.
- DONE: LED, Byte_Sel and Checksum hold their final values. On launch: Done<=0 and the IDLE launch actions apply -> REQ.
- A launch while in REQ/WAIT/SHOW is ignored. No restart and no checksum clear occur.
- Cycles per word = 1 + RD_LAT + 4*DWELL, plus any Hold cycles. Each byte is shown for exactly DWELL unheld cycles.
- LED changes only at capture or on a byte advance. No glitching: LED is registered.
- Mem_Addr never exceeds LAST_ADDR and does not wrap within a scan.
- Hold has no effect outside SHOW.
- Hold asserted on the final dwell cycle blocks the advance until it is released.

Test Plan:
- Setup for all scenarios: LAST_ADDR=3, DWELL=4, RD_LAT=1; RAM model preloaded with 0x00557523, 0x12345678, 0x87654321, 0xFFFFFFFF at addresses 0..3.
- Reset then Start pulse -> Busy rises the edge after the launch. LED shows 0x23,0x75,0x55,0x00 for 4 cycles each, with Byte_Sel 0..3. Mem_Addr then becomes 1.
- Full scan -> LED byte sequence 23 75 55 00 78 56 34 12 21 43 65 87 FF FF FF FF. Done=1 and Busy=0 occur exactly 72 cycles after REQ entry. Final Checksum=0x6AFB9F85. Mem_Write is 0 throughout.
- Hold high for 10 cycles during the byte 0x56 -> 0x56 is displayed for 14 cycles total. Mem_Addr and Checksum are unchanged during the hold.
- Start toggled again mid-scan (at word 2) -> no restart; sequence and final checksum are identical to the full scan. Start edge in DONE -> Done drops, Checksum clears to 0, and the scan repeats with the same results.
- Rst_n low for 1 cycle during SHOW of word 1 -> the next cycle shows all outputs at reset values (LED 0, Mem_Addr 0, Checksum 0, Busy 0) and state is IDLE. A new Start edge gives a full correct scan.
- RD_LAT=2 with a 2-cycle RAM model -> same LED sequence and checksum. Per-word period is 19 cycles; capture occurs 3 cycles after REQ entry.

Source files
------------

// File: rtl/ram_b_scan_reader.sv
// Read-only sequential scanner for RAM_B: walks word addresses 0..LAST_ADDR,
// shows each word one byte at a time on the LEDs and XORs every word into Checksum.
module ram_b_scan_reader #(
   parameter int ADDR_W    = 6,
   parameter int LAST_ADDR = 63,
   parameter int RD_LAT    = 1,
   parameter int DWELL     = 25000000
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Start,
   input  logic              Hold,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic              Mem_Write,
   input  logic [31:0]       M_R_Data,
   output logic [7:0]        LED,
   output logic [1:0]        Byte_Sel,
   output logic              Busy,
   output logic              Done,
   output logic [31:0]       Checksum
);
   localparam int DW_W  = (DWELL > 1)  ? $clog2(DWELL)  : 1;
   localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [DW_W-1:0]   DWELL_END = DW_W'(DWELL - 1);
   localparam logic [LAT_W-1:0]  LAT_END   = LAT_W'(RD_LAT - 1);
   localparam logic [ADDR_W-1:0] ADDR_END  = ADDR_W'(LAST_ADDR);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_SHOW,
      S_DONE
   } state_t;

   state_t            state_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [7:0]        led_reg;
   logic [1:0]        sel_reg;
   logic              busy_reg;
   logic              done_reg;
   logic [31:0]       sum_reg;
   logic [31:0]       word_reg;
   logic [DW_W-1:0]   dwell_reg;
   logic [LAT_W-1:0]  lat_reg;
   logic              start_d_reg;

   logic              launch;
   logic [1:0]        sel_next;
   logic [7:0]        word_bytes [4];

   assign launch   = Start & ~start_d_reg;
   assign sel_next = sel_reg + 2'd1;

   for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
      assign word_bytes[gi] = word_reg[8*gi +: 8];
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_reg   <= S_IDLE;
         addr_reg    <= '0;
         led_reg     <= '0;
         sel_reg     <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         sum_reg     <= '0;
         word_reg    <= '0;
         dwell_reg   <= '0;
         lat_reg     <= '0;
         start_d_reg <= 1'b0;
      end else begin
         start_d_reg <= Start;
         case (state_reg)
            // A launch from DONE behaves exactly like one from IDLE.
            S_IDLE, S_DONE: begin
               if (launch) begin
                  addr_reg  <= '0;
                  sum_reg   <= '0;
                  busy_reg  <= 1'b1;
                  done_reg  <= 1'b0;
                  state_reg <= S_REQ;
               end
            end
            S_REQ: begin
               lat_reg   <= '0;
               state_reg <= S_WAIT;
            end
            S_WAIT: begin
               if (lat_reg == LAT_END) begin
                  word_reg  <= M_R_Data;
                  sum_reg   <= sum_reg ^ M_R_Data;
                  sel_reg   <= 2'd0;
                  led_reg   <= M_R_Data[7:0];
                  dwell_reg <= '0;
                  state_reg <= S_SHOW;
               end else begin
                  lat_reg <= lat_reg + LAT_W'(1);
               end
            end
            S_SHOW: begin
               if (!Hold) begin
                  if (dwell_reg == DWELL_END) begin
                     dwell_reg <= '0;
                     if (sel_reg != 2'd3) begin
                        sel_reg <= sel_next;
                        led_reg <= word_bytes[sel_next];
                     end else if (addr_reg != ADDR_END) begin
                        addr_reg  <= addr_reg + ADDR_W'(1);
                        state_reg <= S_REQ;
                     end else begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                     end
                  end else begin
                     dwell_reg <= dwell_reg + DW_W'(1);
                  end
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign Mem_Addr  = addr_reg;
   assign Mem_Write = 1'b0;
   assign LED       = led_reg;
   assign Byte_Sel  = sel_reg;
   assign Busy      = busy_reg;
   assign Done      = done_reg;
   assign Checksum  = sum_reg;

endmodule
